// File: rtl/lsu_align.sv
// lsu_align: byte/halfword/word load-store alignment in front of a word-only MemCtl.
// Build option LSU_ERR_EN: report misaligned/illegal requests instead of forcing alignment.
module lsu_align #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_RD_LAT = 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_op,
    output logic                  mem_rw,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_w,
    input  logic [DATA_WIDTH-1:0] mem_data_r
);

    // Handshake: a request transfers at a rising edge with req_valid && req_ready;
    // resp_valid is a single-cycle pulse with no back-pressure.

    typedef enum logic [2:0] {IDLE, ISSUE, RMW_RD, WAIT, RMW_WR, RESP} state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam int CNT_W = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;

    state_t state, state_nxt;

    logic [1:0]       op_size, op_size_nxt;
    logic             op_uns, op_uns_nxt;
    logic             op_we, op_we_nxt;
    logic [1:0]       op_lo, op_lo_nxt;
    logic [15:0]      op_wdata, op_wdata_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic                  req_ready_nxt, resp_valid_nxt, resp_err_nxt;
    logic [DATA_WIDTH-1:0] resp_rdata_nxt;
    logic                  mem_op_nxt, mem_rw_nxt;
    logic [ADDR_WIDTH-1:0] mem_addr_nxt;
    logic [DATA_WIDTH-1:0] mem_data_w_nxt;

    logic [1:0]            dec_size;
    logic                  dec_uns, dec_err;
    logic [1:0]            dec_lo;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [DATA_WIDTH-1:0] rd_ext, wr_merge;

    always_comb begin
        dec_size = SZ_W;
        dec_uns  = 1'b0;
        dec_err  = 1'b0;
        case (req_funct3)
            3'b000: dec_size = SZ_B;
            3'b001: dec_size = SZ_H;
            3'b010: dec_size = SZ_W;
            3'b100: begin dec_size = SZ_B; dec_uns = 1'b1; end
            3'b101: begin dec_size = SZ_H; dec_uns = 1'b1; end
            default: begin
                dec_size = SZ_W;
`ifdef LSU_ERR_EN
                dec_err = 1'b1;
`endif
            end
        endcase
        dec_lo = req_addr[1:0];
`ifdef LSU_ERR_EN
        if (dec_size == SZ_H && req_addr[0]) dec_err = 1'b1;
        if (dec_size == SZ_W && req_addr[1:0] != 2'b00) dec_err = 1'b1;
`else
        // Without error reporting the access is silently forced onto its natural boundary.
        if (dec_size == SZ_H) dec_lo[0] = 1'b0;
        if (dec_size == SZ_W) dec_lo = 2'b00;
`endif
    end

    always_comb begin
        rd_byte = mem_data_r[{op_lo, 3'b000} +: 8];
        rd_half = mem_data_r[{op_lo[1], 4'b0000} +: 16];
        case (op_size)
            SZ_B:    rd_ext = op_uns ? {{(DATA_WIDTH-8){1'b0}}, rd_byte}
                                     : {{(DATA_WIDTH-8){rd_byte[7]}}, rd_byte};
            SZ_H:    rd_ext = op_uns ? {{(DATA_WIDTH-16){1'b0}}, rd_half}
                                     : {{(DATA_WIDTH-16){rd_half[15]}}, rd_half};
            default: rd_ext = mem_data_r;
        endcase
        wr_merge = mem_data_r;
        if (op_size == SZ_B) wr_merge[{op_lo, 3'b000} +: 8] = op_wdata[7:0];
        else                 wr_merge[{op_lo[1], 4'b0000} +: 16] = op_wdata;
    end

    // Outputs are registered: each transition loads the output values of the state it enters.
    always_comb begin
        state_nxt      = state;
        op_size_nxt    = op_size;
        op_uns_nxt     = op_uns;
        op_we_nxt      = op_we;
        op_lo_nxt      = op_lo;
        op_wdata_nxt   = op_wdata;
        cnt_nxt        = cnt;
        req_ready_nxt  = 1'b0;
        resp_valid_nxt = 1'b0;
        resp_err_nxt   = 1'b0;
        resp_rdata_nxt = '0;
        mem_op_nxt     = 1'b0;
        mem_rw_nxt     = 1'b0;
        mem_addr_nxt   = mem_addr;
        mem_data_w_nxt = mem_data_w;
        case (state)
            IDLE: begin
                req_ready_nxt = 1'b1;
                if (req_valid && req_ready) begin
                    req_ready_nxt = 1'b0;
                    op_size_nxt   = dec_size;
                    op_uns_nxt    = dec_uns;
                    op_we_nxt     = req_we;
                    op_lo_nxt     = dec_lo;
                    op_wdata_nxt  = req_wdata[15:0];
                    if (dec_err) begin
                        state_nxt      = RESP;
                        resp_valid_nxt = 1'b1;
                        resp_err_nxt   = 1'b1;
                    end else if (!req_we || dec_size == SZ_W) begin
                        state_nxt    = ISSUE;
                        mem_op_nxt   = 1'b1;
                        mem_rw_nxt   = req_we;
                        mem_addr_nxt = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        if (req_we) mem_data_w_nxt = req_wdata;
                    end else begin
                        state_nxt    = RMW_RD;
                        mem_op_nxt   = 1'b1;
                        mem_addr_nxt = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                    end
                end
            end
            ISSUE: begin
                if (op_we) begin
                    state_nxt      = RESP;
                    resp_valid_nxt = 1'b1;
                end else begin
                    state_nxt = WAIT;
                    cnt_nxt   = CNT_W'(MEM_RD_LAT - 1);
                end
            end
            RMW_RD: begin
                state_nxt = WAIT;
                cnt_nxt   = CNT_W'(MEM_RD_LAT - 1);
            end
            WAIT: begin
                if (cnt == '0) begin
                    if (op_we) begin
                        state_nxt      = RMW_WR;
                        mem_op_nxt     = 1'b1;
                        mem_rw_nxt     = 1'b1;
                        mem_data_w_nxt = wr_merge;
                    end else begin
                        state_nxt      = RESP;
                        resp_valid_nxt = 1'b1;
                        resp_rdata_nxt = rd_ext;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            RMW_WR: begin
                state_nxt      = RESP;
                resp_valid_nxt = 1'b1;
            end
            RESP: begin
                state_nxt     = IDLE;
                req_ready_nxt = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state      <= IDLE;
            op_size    <= SZ_W;
            op_uns     <= 1'b0;
            op_we      <= 1'b0;
            op_lo      <= 2'b00;
            op_wdata   <= '0;
            cnt        <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_op     <= 1'b0;
            mem_rw     <= 1'b0;
            mem_addr   <= '0;
            mem_data_w <= '0;
        end else begin
            state      <= state_nxt;
            op_size    <= op_size_nxt;
            op_uns     <= op_uns_nxt;
            op_we      <= op_we_nxt;
            op_lo      <= op_lo_nxt;
            op_wdata   <= op_wdata_nxt;
            cnt        <= cnt_nxt;
            req_ready  <= req_ready_nxt;
            resp_valid <= resp_valid_nxt;
            resp_err   <= resp_err_nxt;
            resp_rdata <= resp_rdata_nxt;
            mem_op     <= mem_op_nxt;
            mem_rw     <= mem_rw_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_data_w <= mem_data_w_nxt;
        end
    end

endmodule

// File: tb/tb_lsu_align.sv
// Bench for lsu_align: word memory model behind MemCtl port, expected-response queue, latency checks.
module tb_lsu_align;

    localparam int LAT   = 1;
    localparam int EXP_W = 41;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_op;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_w;
    logic [31:0] mem_data_r;

    lsu_align #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_RD_LAT(LAT)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_op(mem_op), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_data_w(mem_data_w), .mem_data_r(mem_data_r)
    );

    // clock / cycle counter
    always #5 sys_clk = ~sys_clk;
    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // MemCtl model: op sampled at a rising edge, read data valid LAT edges later
    logic [31:0] mem [0:63];
    logic [31:0] rd_pipe [0:LAT-1];
    int          n_rd = 0, n_wr = 0;
    logic [31:0] last_wr_addr = '0, last_wr_data = '0, last_rd_addr = '0;

    always @(posedge sys_clk) begin
        if (mem_op) begin
            if (mem_rw) begin
                mem[mem_addr[7:2]] <= mem_data_w;
                n_wr         <= n_wr + 1;
                last_wr_addr <= mem_addr;
                last_wr_data <= mem_data_w;
            end else begin
                n_rd         <= n_rd + 1;
                last_rd_addr <= mem_addr;
            end
        end
        rd_pipe[0] <= (mem_op && !mem_rw) ? mem[mem_addr[7:2]] : 32'hBAD0_BAD0;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_data_r = rd_pipe[LAT-1];

    // checking
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // scoreboard: {latency[7:0], err, rdata[31:0]}
    logic [EXP_W-1:0] exp_q[$];
    int               acc_q[$];
    logic [EXP_W-1:0] mon_e;
    int               mon_a;
    int               resp_seen = 0;
    int               last_resp_cyc = 0;

    always @(negedge sys_clk) begin
        if (resp_valid) begin
            resp_seen++;
            last_resp_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_resp", resp_valid, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_a = acc_q.pop_front();
                check("resp_rdata", resp_rdata, mon_e[31:0]);
                check("resp_err", resp_err, mon_e[32]);
                check("resp_latency", 64'(cyc - mon_a + 1), mon_e[40:33]);
            end
        end
    end

    // driver tasks
    task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp_rdata,
                             input logic exp_err, input int exp_lat, input bit hold,
                             input bit chk_b2b);
        int waited;
        int acc;
        waited = 0;
        @(negedge sys_clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        while (!req_ready && waited < 64) begin
            @(negedge sys_clk);
            waited++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", req_ready, 1'b1);
            req_valid = 1'b0;
            return;
        end
        @(posedge sys_clk);
        #1;
        acc = cyc;
        acc_q.push_back(acc);
        exp_q.push_back({8'(exp_lat), exp_err, exp_rdata});
        if (chk_b2b) check("b2b_accept_cycle", acc, last_resp_cyc + 2);
        // fields after acceptance must be ignored
        req_we     = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom_range(0, 7));
        req_addr   = $urandom;
        req_wdata  = $urandom;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge sys_clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        repeat (2) @(negedge sys_clk);
    endtask

    int          s_rd, s_wr, s_resp;
    logic [31:0] b2b_data [0:7];

    initial begin
        // reset
        repeat (3) @(negedge sys_clk);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_err", resp_err, 1'b0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_mem_op", mem_op, 1'b0);
        check("rst_mem_rw", mem_rw, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_data_w", mem_data_w, 32'h0);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("ready_after_rst", req_ready, 1'b1);

        // SW then LW
        s_rd = n_rd; s_wr = n_wr;
        drive_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b0, 1'b0);
        wait_idle();
        check("sw_wr_ops", n_wr - s_wr, 1);
        check("sw_rd_ops", n_rd - s_rd, 0);
        check("sw_wr_addr", last_wr_addr, 32'h10);
        check("sw_wr_data", last_wr_data, 32'hDEADBEEF);
        drive_req(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, LAT + 2, 1'b0, 1'b0);
        wait_idle();

        // SB / SH read-modify-write
        drive_req(1'b1, 3'b010, 32'h20, 32'h11223344, 32'h0, 1'b0, 2, 1'b0, 1'b0);
        wait_idle();
        s_rd = n_rd; s_wr = n_wr;
        drive_req(1'b1, 3'b000, 32'h22, 32'h123456AA, 32'h0, 1'b0, LAT + 3, 1'b0, 1'b0);
        wait_idle();
        check("sb_rd_ops", n_rd - s_rd, 1);
        check("sb_wr_ops", n_wr - s_wr, 1);
        check("sb_merge", last_wr_data, 32'h11AA3344);
        check("sb_wr_addr", last_wr_addr, 32'h20);
        drive_req(1'b0, 3'b010, 32'h20, 32'h0, 32'h11AA3344, 1'b0, LAT + 2, 1'b0, 1'b0);
        drive_req(1'b1, 3'b001, 32'h22, 32'hABCDBEEF, 32'h0, 1'b0, LAT + 3, 1'b0, 1'b0);
        wait_idle();
        check("sh_merge", last_wr_data, 32'hBEEF3344);
        drive_req(1'b0, 3'b101, 32'h22, 32'h0, 32'h0000BEEF, 1'b0, LAT + 2, 1'b0, 1'b0);
        drive_req(1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFFBEEF, 1'b0, LAT + 2, 1'b0, 1'b0);

        // extension rules on 0x80FF7F01
        drive_req(1'b1, 3'b010, 32'h30, 32'h80FF7F01, 32'h0, 1'b0, 2, 1'b0, 1'b0);
        drive_req(1'b0, 3'b000, 32'h32, 32'h0, 32'hFFFFFFFF, 1'b0, LAT + 2, 1'b0, 1'b0);
        drive_req(1'b0, 3'b100, 32'h32, 32'h0, 32'h000000FF, 1'b0, LAT + 2, 1'b0, 1'b0);
        drive_req(1'b0, 3'b001, 32'h32, 32'h0, 32'hFFFF80FF, 1'b0, LAT + 2, 1'b0, 1'b0);
        drive_req(1'b0, 3'b101, 32'h30, 32'h0, 32'h00007F01, 1'b0, LAT + 2, 1'b0, 1'b0);
        drive_req(1'b0, 3'b000, 32'h31, 32'h0, 32'h0000007F, 1'b0, LAT + 2, 1'b0, 1'b0);
        drive_req(1'b0, 3'b100, 32'h33, 32'h0, 32'h00000080, 1'b0, LAT + 2, 1'b0, 1'b0);
        wait_idle();

        // misaligned / illegal
        s_rd = n_rd; s_wr = n_wr;
`ifdef LSU_ERR_EN
        drive_req(1'b0, 3'b010, 32'h31, 32'h0, 32'h0, 1'b1, 1, 1'b0, 1'b0);
        drive_req(1'b1, 3'b001, 32'h33, 32'h5A5A, 32'h0, 1'b1, 1, 1'b0, 1'b0);
        drive_req(1'b0, 3'b011, 32'h30, 32'h0, 32'h0, 1'b1, 1, 1'b0, 1'b0);
        wait_idle();
        check("err_no_rd_ops", n_rd - s_rd, 0);
        check("err_no_wr_ops", n_wr - s_wr, 0);
`else
        drive_req(1'b0, 3'b010, 32'h31, 32'h0, 32'h80FF7F01, 1'b0, LAT + 2, 1'b0, 1'b0);
        wait_idle();
        check("misalign_rd_addr", last_rd_addr, 32'h30);
        drive_req(1'b0, 3'b001, 32'h33, 32'h0, 32'hFFFF80FF, 1'b0, LAT + 2, 1'b0, 1'b0);
        drive_req(1'b0, 3'b011, 32'h32, 32'h0, 32'h80FF7F01, 1'b0, LAT + 2, 1'b0, 1'b0);
        wait_idle();
        check("misalign_rd_ops", n_rd - s_rd, 3);
        check("misalign_wr_ops", n_wr - s_wr, 0);
`endif

        // reset in the middle of an RMW
        drive_req(1'b1, 3'b010, 32'h40, 32'h01234567, 32'h0, 1'b0, 2, 1'b0, 1'b0);
        wait_idle();
        s_rd = n_rd; s_wr = n_wr; s_resp = resp_seen;
        @(negedge sys_clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h40; req_wdata = 32'hABCD5555;
        check("rmw_ready", req_ready, 1'b1);
        @(posedge sys_clk);
        #1;
        req_valid = 1'b0;
        check("rmw_rd_op", mem_op, 1'b1);
        check("rmw_rd_rw", mem_rw, 1'b0);
        @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("midrst_mem_op", mem_op, 1'b0);
        check("midrst_req_ready", req_ready, 1'b0);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("midrst_ready_after", req_ready, 1'b1);
        repeat (4) @(negedge sys_clk);
        check("midrst_rd_ops", n_rd - s_rd, 1);
        check("midrst_wr_ops", n_wr - s_wr, 0);
        check("midrst_resp", resp_seen - s_resp, 0);
        check("midrst_mem_word", mem[16], 32'h01234567);
        drive_req(1'b0, 3'b001, 32'h40, 32'h0, 32'h00004567, 1'b0, LAT + 2, 1'b0, 1'b0);
        wait_idle();

        // back-to-back with req_valid held high
        for (int i = 0; i < 8; i++) b2b_data[i] = $urandom;
        for (int i = 0; i < 8; i++)
            drive_req(1'b1, 3'b010, 32'(i * 4), b2b_data[i], 32'h0, 1'b0, 2, 1'b1, i != 0);
        for (int i = 0; i < 8; i++)
            drive_req(1'b0, 3'b010, 32'(i * 4), 32'h0, b2b_data[i], 1'b0, LAT + 2, 1'b1, 1'b1);
        req_valid = 1'b0;
        wait_idle();

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: time limit reached with %0d responses pending", exp_q.size());
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_align.md
Name: lsu_align

Overview:
- Load/store alignment stage directly upstream of MemCtl.
- Accepts RISC-V byte, halfword and word load/store requests from the core.
- Drives MemCtl's word-only op/rw/addr/data_w interface and sign- or zero-extends the returned data.
- Sub-word stores are performed as read-modify-write, because MemCtl writes whole words only.

Parameters:
- ADDR_WIDTH, 32, request/memory address width in bits.
- DATA_WIDTH, 32, data width in bits; only 32 is supported.
- MEM_RD_LAT, 1, cycles from the MemCtl sampling edge of a read op to the edge at which mem_data_r is valid (≥1).

Ports:
- sys_clk  in  1  clock; all logic on rising edge.
- sys_rst  in  1  reset; synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at an edge.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores.
- resp_err  out  1  misaligned or illegal access; valid with resp_valid.
- mem_op  out  1  to MemCtl op.
- mem_rw  out  1  to MemCtl rw; 1 = write.
- mem_addr  out  ADDR_WIDTH  to MemCtl addr; word-aligned, {req_addr[ADDR_WIDTH-1:2], 2'b00}.
- mem_data_w  out  DATA_WIDTH  to MemCtl data_w.
- mem_data_r  in  DATA_WIDTH  from MemCtl data_r.

Behaviour:
- Reset (sys_rst=0 at an edge):
  - State goes to IDLE.
  - req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_op=0, mem_rw=0, mem_addr=0, mem_data_w=0.
  - req_ready rises the cycle after reset is released.
- All outputs are registered. Little-endian byte lanes: byte lane = addr[1:0], halfword lane = addr[1].
- States:
  - IDLE: req_ready=1. On acceptance at edge E:
    - LW/SW or aligned load → ISSUE.
    - Sub-word store → RMW_RD.
    - Error → RESP.
  - ISSUE: mem_op=1 for exactly one cycle. mem_rw=req_we. For SW, mem_data_w=req_wdata.
    - Load → WAIT.
    - Store → RESP.
  - RMW_RD: mem_op=1, mem_rw=0 for one cycle → WAIT.
  - WAIT: counts MEM_RD_LAT edges, then captures mem_data_r.
    - Load → RESP, with the extended lane in resp_rdata.
    - Sub-word store → RMW_WR, with the merged word in mem_data_w (only the addressed byte/halfword replaced by req_wdata[7:0]/[15:0]).
  - RMW_WR: mem_op=1, mem_rw=1 for one cycle → RESP.
  - RESP: resp_valid=1 for one cycle → IDLE. req_ready is 0 in RESP; a new request can be accepted the following cycle.
- Latency (cycles from acceptance edge E to the resp_valid cycle):
  - Store word: mem_op in cycle E..E+1; resp_valid in cycle after E+1.
  - Load: capture at E+1+MEM_RD_LAT; resp_valid in the following cycle (3 cycles at MEM_RD_LAT=1).
  - Sub-word store: read op, capture at E+1+MEM_RD_LAT, write op next cycle, then resp (4 cycles at MEM_RD_LAT=1).
- Extension rules:
  - LB: sign-extends bit 7 of the lane.
  - LH: sign-extends bit 15 of the lane.
  - LBU/LHU: zero-extend.
- Request fields are latched at acceptance; req_* changes afterwards are ignored.
- Misalignment:
  - H/HU with addr[0]=1.
  - W with addr[1:0]≠0.
  - illegal funct3 (011, 110, 111).
- Reset mid-operation: the access is abandoned. An RMW interrupted before RMW_WR leaves memory unchanged, and no resp_valid is produced.

Optional Feature:
- LSU_ERR_EN defined:
  - Misaligned or illegal requests skip all memory ops and go IDLE→RESP with resp_err=1 and resp_rdata=0.
  - resp_valid for an error occurs 1 cycle after acceptance.
- LSU_ERR_EN undefined:
  - resp_err is tied 0.
  - Address low bits are forced to alignment: H clears bit 0, W clears bits 1:0.
  - Illegal funct3 is treated as W.
  - The access proceeds normally.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 → single write op with mem_addr=0x10; load resp_rdata=0xDEADBEEF, resp_err=0, resp_valid 3 cycles after acceptance (MEM_RD_LAT=1).
- Word @0x20 = 0x11223344; SB 0xAA @0x22 → read op then write op with mem_data_w=0x11AA3344; subsequent LW returns 0x11AA3344.
- Word @0x30 = 0x80FF7F01: LB @0x32 → 0xFFFFFFFF; LBU @0x32 → 0x000000FF; LH @0x32 → 0xFFFF80FF; LHU @0x30 → 0x00007F01.
- LW @0x31 with LSU_ERR_EN: mem_op stays 0, resp_err=1 one cycle after acceptance. Without LSU_ERR_EN: accesses 0x30, resp_err=0.
- SH 0x5555 @0x40, with sys_rst driven low in the cycle after the RMW read op → no write op, no resp_valid, word @0x40 unchanged; req_ready=1 one cycle after reset release.
- Back-to-back: 8 consecutive SW then 8 LW at 0x00..0x1C holding req_valid=1 → each accepted the cycle after the previous resp_valid; all data match.
